// File: rtl/alu_array_pipe.sv
// alu_array_pipe: CHANNELS independent WIDTH-bit ALU lanes behind a two-stage
// valid/ready pipeline (S1 operand register, S2 result register). Each lane has
// an accumulate mode that replaces operand A with a per-lane accumulator. A
// saturating counter tracks output handshakes that carry any lane carry/borrow.

// One ALU lane. The result is combinational from the S1 operands. The
// accumulator sits here because only this lane reads or writes it.
module alu_array_pipe_lane #(
  parameter int WIDTH = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             i_clr,
  input  logic             i_upd,
  input  logic             i_acc,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_sel,
  output logic [WIDTH:0]   o_res
);
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_a;

  assign w_a = i_acc ? r_acc : i_a;

  // Lane op. The MSB holds the carry for add, the borrow for sub, and 0 otherwise.
  always_comb begin
    o_res = '0;
    case (i_sel)
      2'b00:   o_res = {1'b0, w_a} + {1'b0, i_b};
      2'b01:   o_res = {w_a < i_b, w_a - i_b};
      2'b10:   o_res = {1'b0, w_a & i_b};
      default: o_res = {1'b0, w_a ^ i_b};
    endcase
  end

  // Accumulator: clear beats the write-back of the transaction leaving S1.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || i_clr) r_acc <= '0;
    else if (i_upd)        r_acc <= o_res[WIDTH-1:0];
  end
endmodule

module alu_array_pipe #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [CHANNELS*WIDTH-1:0]     a_i,
  input  logic [CHANNELS*WIDTH-1:0]     b_i,
  input  logic [CHANNELS*2-1:0]         sel_i,
  input  logic [CHANNELS-1:0]           acc_i,
  input  logic                          clr_acc_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [CHANNELS*(WIDTH+1)-1:0] res_o,
  output logic [CHANNELS-1:0]           zero_o,
  output logic [CNT_W-1:0]              carry_cnt_o
);
  // Stage valids: [1] = S1 operands held, [2] = S2 result held.
  logic [2:1]                          r_vld_pipe;
  logic [CHANNELS-1:0][WIDTH-1:0]      r_s1_a, r_s1_b;
  logic [CHANNELS-1:0][1:0]            r_s1_sel;
  logic [CHANNELS-1:0]                 r_s1_acc;
  logic [CHANNELS-1:0][WIDTH:0]        r_res;
  logic [CHANNELS-1:0]                 r_zero;
  logic [CNT_W-1:0]                    r_cnt;

  logic [CHANNELS-1:0][WIDTH:0]        w_res;
  logic [CHANNELS-1:0]                 w_zero, w_msb, w_upd;
  logic                                w_s1_adv, w_s2_adv, w_out_hs;

  // S2 frees up when empty or drained this cycle. This is the only
  // combinational path from an input (out_ready_i) to an output (in_ready_o).
  assign w_s2_adv   = !r_vld_pipe[2] || out_ready_i;
  assign w_s1_adv   = r_vld_pipe[1] && w_s2_adv;
  assign in_ready_o = !r_vld_pipe[1] || w_s2_adv;
  assign w_out_hs   = r_vld_pipe[2] && out_ready_i;
  assign w_upd      = {CHANNELS{w_s1_adv}} & r_s1_acc;

  alu_array_pipe_lane #(.WIDTH(WIDTH)) u_lane [CHANNELS-1:0] (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .i_clr    (clr_acc_i),
    .i_upd    (w_upd),
    .i_acc    (r_s1_acc),
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .i_sel    (r_s1_sel),
    .o_res    (w_res)
  );

  // Per-lane zero flag for the next result, and carry flags of the held result.
  always_comb begin
    w_zero = '0;
    w_msb  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_zero[k] = (w_res[k][WIDTH-1:0] == '0);
      w_msb[k]  = r_res[k][WIDTH];
    end
  end

  // S1 valid: refills on an input handshake and empties when it advances.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)        r_vld_pipe[1] <= 1'b0;
    else if (in_ready_o) r_vld_pipe[1] <= in_valid_i;
  end

  // S1 operands. They need no reset because the valid bit qualifies them.
  always_ff @(posedge wb_clk_i) begin
    if (in_valid_i && in_ready_o) begin
      r_s1_a   <= a_i;
      r_s1_b   <= b_i;
      r_s1_sel <= sel_i;
      r_s1_acc <= acc_i;
    end
  end

  // S2 result register. It holds steady while stalled downstream.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_vld_pipe[2] <= 1'b0;
      r_res         <= '0;
      r_zero        <= '0;
    end else if (w_s2_adv) begin
      r_vld_pipe[2] <= r_vld_pipe[1];
      if (w_s1_adv) begin
        r_res  <= w_res;
        r_zero <= w_zero;
      end
    end
  end

  // Saturating count of output handshakes that carry any lane MSB.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                                 r_cnt <= '0;
    else if (w_out_hs && |w_msb && r_cnt != '1)   r_cnt <= r_cnt + 1'b1;
  end

  assign out_valid_o = r_vld_pipe[2];
  assign res_o       = r_res;
  assign zero_o      = r_zero;
  assign carry_cnt_o = r_cnt;
endmodule

// File: tb/tb_alu_array_pipe.sv
// Bench for alu_array_pipe (WIDTH=4, CHANNELS=2, CNT_W=2). The bench uses
// directed scenarios and then random traffic. A transaction-level model predicts
// every result. The model is an in-order queue of expected results, per-lane
// accumulators, and a saturating counter. The bench checks each cycle
// against that model.
module tb_alu_array_pipe;
  localparam int W = 4, C = 2, CW = 2;

  logic           clk = 1'b0;
  logic           rst, in_valid, out_ready, clr;
  logic [C*W-1:0] a, b;
  logic [C*2-1:0] sel;
  logic [C-1:0]   acc;
  logic           in_ready, out_valid;
  logic [C*(W+1)-1:0] res;
  logic [C-1:0]   zero;
  logic [CW-1:0]  cnt;

  alu_array_pipe #(.WIDTH(W), .CHANNELS(C), .CNT_W(CW)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .sel_i       (sel),
    .acc_i       (acc),
    .clr_acc_i   (clr),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .res_o       (res),
    .zero_o      (zero),
    .carry_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [C*(W+1)-1:0] res;
    logic [C-1:0]       zero;
    int                 c;
  } exp_t;

  exp_t       q[$];
  logic [W-1:0] macc [C];
  int         m_cnt = 0, cyc = 0, n_out = 0;
  int         total = 0, bad = 0;
  bit         chk_on = 0;
  int         exp_cnt[7] = '{0, 0, 1, 2, 3, 3, 3};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [W:0] lane_ref(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [1:0] s);
    int ix = int'(x), iy = int'(y), r;
    case (s)
      2'd0:    r = ix + iy;
      2'd1:    begin r = ix - iy; if (r < 0) r = r + 32; end
      2'd2:    r = ix & iy;
      default: r = ix ^ iy;
    endcase
    return 5'(r);
  endfunction

  // One clock: check outputs at the negedge, then update the model at the posedge.
  task automatic tick();
    logic ih, oh;
    exp_t e;
    logic [W-1:0] opa;
    logic [W:0]   r;
    @(negedge clk);
    ih = in_valid && in_ready;
    oh = out_valid && out_ready;
    if (chk_on) begin
      chk("out_valid", out_valid, (q.size() > 0) ? (cyc > q[0].c) : 1'b0);
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      chk("carry_cnt", cnt, m_cnt);
      if (out_valid && q.size() > 0) begin
        chk("res", res, q[0].res);
        chk("zero", zero, q[0].zero);
      end
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      for (int k = 0; k < C; k++) macc[k] = '0;
      m_cnt = 0;
    end else begin
      if (oh && q.size() > 0) begin
        e = q.pop_front();
        n_out++;
        if ((e.res[W] || e.res[2*W+1]) && m_cnt < 3) m_cnt++;
      end
      if (clr) for (int k = 0; k < C; k++) macc[k] = '0;
      if (ih) begin
        for (int k = 0; k < C; k++) begin
          opa = acc[k] ? macc[k] : a[k*W +: W];
          r   = lane_ref(opa, b[k*W +: W], sel[k*2 +: 2]);
          e.res[k*(W+1) +: W+1] = r;
          e.zero[k] = (r[W-1:0] == '0);
          if (acc[k]) macc[k] = r[W-1:0];
        end
        e.c = cyc;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic op(input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [1:0] s0,
                    input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [1:0] s1,
                    input logic [C-1:0] ac);
    a = {a1, a0}; b = {b1, b0}; sel = {s1, s0}; acc = ac; in_valid = 1'b1;
  endtask

  initial begin
    logic [C*(W+1)-1:0] snap;
    int n0;
    rst = 1; in_valid = 0; out_ready = 1; clr = 0; a = '0; b = '0; sel = '0; acc = '0;
    for (int k = 0; k < C; k++) macc[k] = '0;
    tick();
    chk_on = 1;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_zero", zero, 0);
    chk("rst_cnt", cnt, 0);
    rst = 0;
    tick();
    chk("rst_in_ready", in_ready, 1);

    // add 9+9 and sub 3-5
    op(4'd9, 4'd9, 2'b00, 4'd3, 4'd5, 2'b01, 2'b00);
    tick();
    in_valid = 0;
    chk("lat_not_yet", out_valid, 0);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_res", res, {5'b11110, 5'b10010});
    chk("t1_zero", zero, 2'b00);
    tick();
    chk("t1_cnt", cnt, 1);

    // AND / XOR, counter must not move
    op(4'hC, 4'hA, 2'b10, 4'hF, 4'hF, 2'b11, 2'b00);
    tick();
    in_valid = 0;
    tick();
    chk("t2_res", res, {5'b00000, 5'b01000});
    chk("t2_zero", zero, 2'b10);
    tick();
    chk("t2_cnt", cnt, 1);

    // accumulate chain 3, 6, 9, then clear and add 5
    op(4'd0, 4'd3, 2'b00, 4'd0, 4'd0, 2'b00, 2'b01);
    tick(); tick();
    chk("acc_3", res[W:0], 3);
    tick();
    in_valid = 0;
    chk("acc_6", res[W:0], 6);
    tick();
    chk("acc_9", res[W:0], 9);
    op(4'd0, 4'd5, 2'b00, 4'd0, 4'd0, 2'b00, 2'b01);
    clr = 1;
    tick();
    clr = 0; in_valid = 0;
    tick();
    chk("acc_clr_5", res[W:0], 5);
    tick();

    // stall: three sets offered with out_ready low
    out_ready = 0;
    op(4'd1, 4'd2, 2'b00, 4'd7, 4'd3, 2'b01, 2'b00);
    tick();
    op(4'd6, 4'd6, 2'b10, 4'd9, 4'd4, 2'b11, 2'b00);
    tick();
    op(4'd15, 4'd15, 2'b00, 4'd2, 4'd8, 2'b01, 2'b00);
    chk("stall_full", in_ready, 0);
    snap = res;
    n0 = n_out;
    tick();
    chk("stall_hold_ready", in_ready, 0);
    chk("stall_hold_res", res, snap);
    tick();
    chk("stall_hold_res2", res, snap);
    out_ready = 1;
    tick();
    in_valid = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("stall_delivered", n_out - n0, 3);
    chk("stall_drained", q.size(), 0);

    // counter saturation at 3
    rst = 1; tick(); rst = 0;
    op(4'd15, 4'd1, 2'b00, 4'd0, 4'd0, 2'b10, 2'b00);
    for (int i = 0; i < 7; i++) begin
      if (i == 5) in_valid = 0;
      tick();
      chk("sat_cnt", cnt, exp_cnt[i]);
    end

    // reset with both stages full
    out_ready = 0;
    op(4'd0, 4'd7, 2'b00, 4'd1, 4'd1, 2'b00, 2'b01);
    tick();
    op(4'd0, 4'd1, 2'b00, 4'd2, 4'd2, 2'b00, 2'b01);
    tick();
    chk("full_before_rst", in_ready, 0);
    in_valid = 0; out_ready = 1; rst = 1;
    n0 = n_out;
    tick();
    rst = 0;
    chk("rst2_valid", out_valid, 0);
    chk("rst2_ready", in_ready, 1);
    chk("rst2_res", res, 0);
    tick(); tick();
    chk("rst2_no_hs", n_out - n0, 0);
    op(4'd0, 4'd2, 2'b00, 4'd0, 4'd0, 2'b00, 2'b01);
    tick();
    in_valid = 0;
    tick();
    chk("rst2_acc_zero", res[W:0], 2);
    tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      a   = C*W'($urandom);
      b   = C*W'($urandom);
      sel = (C*2)'($urandom);
      acc = C'($urandom);
      clr = out_ready && ($urandom_range(0, 19) == 0);
      tick();
    end
    in_valid = 0; out_ready = 1; clr = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("final_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
